// File: rtl/valu_pipe.sv
// Registered, handshaked vector ALU for the execute stage. It applies each op per lane
// (8/16/32/64 bits), with a multi-cycle unsigned lane-pair multiply that stalls the input.
module valu_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:DATA_WIDTH-1] ra,
  input  logic [0:DATA_WIDTH-1] rb,
  input  logic [0:13]           ex_alu_ctrl,
  input  logic                  ex2alu_regwrite,
  input  logic [0:4]            alu_imme,
  input  logic [0:4]            in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:DATA_WIDTH-1] alu_out,
  output logic                  alu2wb_regwrite,
  output logic [0:4]            out_tag,
  output logic                  busy
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic load_out, load_mul, accept;

  logic [DATA_WIDTH-1:0] mul_a, mul_b;
  logic [1:0] mul_ww;
  logic [5:0] mul_func;
  logic mul_rw;
  logic [4:0] mul_tag;

  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [1:0] op_ww;
  logic [5:0] op_func;
  logic [4:0] op_imm;
  logic op_rw;
  logic [4:0] op_tag;
  logic op_is_mul, op_valid;
  logic [DATA_WIDTH-1:0] lane_sel, res_final;

  logic unused_opcode;
  assign unused_opcode = ^ex_alu_ctrl[0:5];

  assign busy     = (state == MUL);
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // One shared ALU: it sees the live inputs when idle and the latched multiply operands in MUL.
  always_comb begin
    op_a    = ra;
    op_b    = rb;
    op_ww   = ex_alu_ctrl[6:7];
    op_func = ex_alu_ctrl[8:13];
    op_rw   = ex2alu_regwrite;
    op_tag  = in_tag;
    op_imm  = alu_imme;
    if (state == MUL) begin
      op_a    = mul_a;
      op_b    = mul_b;
      op_ww   = mul_ww;
      op_func = mul_func;
      op_rw   = mul_rw;
      op_tag  = mul_tag;
    end
  end

  assign op_is_mul = (op_func == 6'd7) || (op_func == 6'd8);
  assign op_valid  = (op_func <= 6'd17) && !(op_is_mul && (op_ww == 2'd3));

  for (genvar gs = 0; gs < 4; gs++) begin : g_size
    localparam int LW = 8 << gs;
    localparam int NL = DATA_WIDTH / LW;
    localparam int SW = $clog2(LW);
    localparam int IW = (SW < 5) ? SW : 5;
    logic [DATA_WIDTH-1:0] res;

    for (genvar gl = 0; gl < NL; gl++) begin : g_lane
      localparam int LO = DATA_WIDTH - (gl + 1) * LW;
      logic [LW-1:0] a, b, r;
      logic [LW:0] sum_c;
      logic [SW-1:0] sh_r, sh_i;

      assign a     = op_a[LO +: LW];
      assign b     = op_b[LO +: LW];
      assign sum_c = {1'b0, a} + {1'b0, b};
      assign sh_r  = b[SW-1:0];
      assign sh_i  = SW'(op_imm[IW-1:0]);

      always_comb begin
        r = '0;
        case (op_func)
          6'd0:  r = a & b;
          6'd1:  r = a | b;
          6'd2:  r = a ^ b;
          6'd3:  r = ~a;
          6'd4:  r = a;
          6'd5:  r = a + b;
          6'd6:  r = a - b;
          6'd9:  r = {a[LW/2-1:0], a[LW-1:LW/2]};
          6'd10: r = a << sh_r;
          6'd11: r = a << sh_i;
          6'd12: r = a >> sh_r;
          6'd13: r = a >> sh_i;
          6'd14: r = $signed(a) >>> sh_r;
          6'd15: r = $signed(a) >>> sh_i;
          6'd16: r = sum_c[LW] ? '1 : sum_c[LW-1:0];
          6'd17: r = (a < b) ? '0 : (a - b);
          default: r = '0;
        endcase
      end

      assign res[LO +: LW] = r;
    end

    // Each even/odd lane product is double width and lands across the lane pair it came from.
    if (gs < 3) begin : g_mul
      logic [DATA_WIDTH-1:0] mres;
      for (genvar gp = 0; gp < NL / 2; gp++) begin : g_pair
        localparam int PLO = DATA_WIDTH - (2 * gp + 2) * LW;
        logic [2*LW-1:0] xa, xb;
        assign xa = (op_func == 6'd8) ? {{LW{1'b0}}, op_a[PLO +: LW]}
                                      : {{LW{1'b0}}, op_a[PLO+LW +: LW]};
        assign xb = (op_func == 6'd8) ? {{LW{1'b0}}, op_b[PLO +: LW]}
                                      : {{LW{1'b0}}, op_b[PLO+LW +: LW]};
        assign mres[PLO +: 2*LW] = xa * xb;
      end
    end
  end

  always_comb begin
    lane_sel = '0;
    case (op_ww)
      2'd0:    lane_sel = op_is_mul ? g_size[0].g_mul.mres : g_size[0].res;
      2'd1:    lane_sel = op_is_mul ? g_size[1].g_mul.mres : g_size[1].res;
      2'd2:    lane_sel = op_is_mul ? g_size[2].g_mul.mres : g_size[2].res;
      default: lane_sel = op_is_mul ? '0 : g_size[3].res;
    endcase
  end

  assign res_final = op_valid ? lane_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_is_mul) begin
            state_nxt = MUL;
            load_mul  = 1'b1;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          load_out  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ww   <= '0;
      mul_func <= '0;
      mul_rw   <= 1'b0;
      mul_tag  <= '0;
    end else if (load_mul) begin
      cnt      <= CW'(MUL_CYCLES - 1);
      mul_a    <= op_a;
      mul_b    <= op_b;
      mul_ww   <= op_ww;
      mul_func <= op_func;
      mul_rw   <= op_rw;
      mul_tag  <= op_tag;
    end else if ((state == MUL) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Output register; a multiply accept drops a draining beat since the next load is cycles away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      alu_out         <= '0;
      alu2wb_regwrite <= 1'b0;
      out_tag         <= '0;
    end else if (load_out) begin
      out_valid       <= 1'b1;
      alu_out         <= res_final;
      alu2wb_regwrite <= op_rw && op_valid;
      out_tag         <= op_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
